// File: rtl/ps2_scancode_queue.sv
// PS/2 scancode FIFO with sticky parity/overflow flags behind a two-register CPU view.
// A scancode read pops one byte on the cycle after the bus access ends.
module ps2_scancode_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_scancode,
    input  logic        scancode_ready_set,
    input  logic        parity_error,
    input  logic        status_cs,
    input  logic        scancode_cs,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        not_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  parity_sticky;
    logic                  overflow_sticky;
    logic                  access_d;
    logic                  access_blocked;

    logic access;
    logic pop_trigger;
    logic do_pop;
    logic full;
    logic flush;
    logic parity_clear;
    logic overflow_clear;
    logic push_accept;
    logic parity_set;
    logic overflow_set;
    logic unused_bits;

    assign access         = scancode_cs & read;
    assign pop_trigger    = access_d & ~access;
    assign not_empty      = (count != '0);
    assign full           = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop         = pop_trigger & not_empty;
    assign flush          = status_cs & write & data_in[31];
    assign parity_clear   = status_cs & write & data_in[30];
    assign overflow_clear = status_cs & write & data_in[29];
    assign unused_bits    = ^data_in[28:0];

    // A pop frees the slot a full FIFO needs, so push and pop coexist when full.
    assign push_accept  = scancode_ready_set & ~parity_error & (~full | do_pop);
    assign parity_set   = scancode_ready_set & parity_error & ~flush;
    assign overflow_set = scancode_ready_set & ~parity_error & full & ~do_pop & ~flush;

    // access_blocked swallows any access still in progress when reset was applied.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            parity_sticky   <= 1'b0;
            overflow_sticky <= 1'b0;
            access_d        <= 1'b0;
            access_blocked  <= access;
        end else begin
            access_d        <= access & ~access_blocked;
            access_blocked  <= access_blocked & access;
            parity_sticky   <= parity_set | (parity_sticky & ~parity_clear);
            overflow_sticky <= overflow_set | (overflow_sticky & ~overflow_clear);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_accept, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush && push_accept) begin
            mem[wr_ptr] <= rx_scancode;
        end
    end

    always_comb begin
        data_out = 32'h0;
        if (status_cs) begin
            data_out = {not_empty, parity_sticky, overflow_sticky, 5'(count), 24'h0};
        end else if (scancode_cs && not_empty) begin
            data_out = {mem[rd_ptr], 24'h0};
        end
    end

endmodule

// File: tb/tb_ps2_scancode_queue.sv
// Self-checking bench for ps2_scancode_queue: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_ps2_scancode_queue;

    logic        clock;
    logic        reset;
    logic [7:0]  rx_scancode;
    logic        scancode_ready_set;
    logic        parity_error;
    logic        status_cs;
    logic        scancode_cs;
    logic        read;
    logic        write;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        not_empty;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] sampled_dout;
    logic        sampled_ne;

    // Reference model state.
    bit [7:0] m_q[$];
    bit       m_par;
    bit       m_ovf;
    bit       m_in_access;
    bit       m_tainted;

    typedef struct {
        bit        rst;
        bit        rs;
        bit [7:0]  rx;
        bit        pe;
        bit        st;
        bit        sc;
        bit        rd;
        bit        wr;
        bit [31:0] din;
        bit        chk;
        bit [31:0] exp_dout;
        bit        exp_ne;
    } vec_t;

    vec_t vecs[17];

    ps2_scancode_queue #(.DEPTH_LOG2(3)) dut (
        .clock              (clock),
        .reset              (reset),
        .rx_scancode        (rx_scancode),
        .scancode_ready_set (scancode_ready_set),
        .parity_error       (parity_error),
        .status_cs          (status_cs),
        .scancode_cs        (scancode_cs),
        .read               (read),
        .write              (write),
        .data_in            (data_in),
        .data_out           (data_out),
        .not_empty          (not_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] model_dout(input bit st, input bit sc);
        if (st) begin
            return {(m_q.size() != 0), m_par, m_ovf, 5'(m_q.size()), 24'h0};
        end
        if (sc && m_q.size() != 0) begin
            return {m_q[0], 24'h0};
        end
        return 32'h0;
    endfunction

    // Pop happens on the first idle cycle after an access, unless reset interrupted that access.
    task automatic model_update(input bit rst, input bit rs, input bit [7:0] rx, input bit pe,
                                input bit st, input bit sc, input bit rd, input bit wr,
                                input bit [31:0] din);
        bit acc;
        bit trig;
        bit popped;
        bit was_full;
        bit pset;
        bit oset;
        acc = sc & rd;
        if (rst) begin
            m_q.delete();
            m_par       = 1'b0;
            m_ovf       = 1'b0;
            m_in_access = acc;
            m_tainted   = acc;
            return;
        end
        trig = m_in_access && !acc && !m_tainted;
        if (!acc) m_tainted = 1'b0;
        m_in_access = acc;
        pset = 1'b0;
        oset = 1'b0;
        if (st && wr && din[31]) begin
            m_q.delete();
        end else begin
            popped   = trig && (m_q.size() != 0);
            was_full = (m_q.size() == 8);
            if (popped) void'(m_q.pop_front());
            if (rs) begin
                if (pe) pset = 1'b1;
                else if (was_full && !popped) oset = 1'b1;
                else m_q.push_back(rx);
            end
        end
        if (st && wr && din[30]) m_par = 1'b0;
        if (st && wr && din[29]) m_ovf = 1'b0;
        if (pset) m_par = 1'b1;
        if (oset) m_ovf = 1'b1;
    endtask

    task automatic apply_stimulus(input bit rst, input bit rs, input bit [7:0] rx, input bit pe,
                                  input bit st, input bit sc, input bit rd, input bit wr,
                                  input bit [31:0] din);
        reset              = rst;
        scancode_ready_set = rs;
        rx_scancode        = rx;
        parity_error       = pe;
        status_cs          = st;
        scancode_cs        = sc;
        read               = rd;
        write              = wr;
        data_in            = din;
        #1;
        sampled_dout = data_out;
        sampled_ne   = not_empty;
        if (!rst) begin
            check_output("model_data_out", data_out, model_dout(st, sc));
            check_output("model_not_empty", {31'h0, not_empty}, {31'h0, (m_q.size() != 0)});
        end
        @(posedge clock);
        model_update(rst, rs, rx, pe, st, sc, rd, wr, din);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic push(input bit [7:0] b);
        apply_stimulus(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic sc_read();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic st_read();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic st_write(input bit [31:0] din);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, din);
    endtask

    function automatic vec_t mk(input bit rst, input bit rs, input bit [7:0] rx, input bit pe,
                                input bit st, input bit sc, input bit rd, input bit wr,
                                input bit [31:0] din, input bit chk, input bit [31:0] exp_dout,
                                input bit exp_ne);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rx = rx; v.pe = pe;
        v.st = st; v.sc = sc; v.rd = rd; v.wr = wr; v.din = din;
        v.chk = chk; v.exp_dout = exp_dout; v.exp_ne = exp_ne;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        vecs[4]  = mk(1'b0, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        vecs[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h83000000, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1C000000, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h32000000, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h21000000, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40000000, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40000000, 1'b1, 32'h40000000, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].rs, vecs[i].rx, vecs[i].pe, vecs[i].st,
                           vecs[i].sc, vecs[i].rd, vecs[i].wr, vecs[i].din);
            if (vecs[i].chk) begin
                check_output($sformatf("vec%0d_data_out", i), sampled_dout, vecs[i].exp_dout);
                check_output($sformatf("vec%0d_not_empty", i), {31'h0, sampled_ne}, {31'h0, vecs[i].exp_ne});
            end
        end

        // Overflow: nine pushes into an eight-entry FIFO.
        for (int i = 1; i <= 9; i++) push(8'(i));
        st_read();
        check_output("ovf_status", sampled_dout, 32'hA8000000);
        for (int i = 1; i <= 8; i++) begin
            sc_read();
            check_output($sformatf("ovf_read%0d", i), sampled_dout, {8'(i), 24'h0});
            idle();
        end
        st_write(32'h20000000);
        check_output("ovf_before_clear", sampled_dout, 32'h20000000);
        st_read();
        check_output("ovf_after_clear", sampled_dout, 32'h0);

        // A long access shows a stable head and pops once.
        push(8'hAA);
        push(8'hBB);
        for (int i = 0; i < 4; i++) begin
            sc_read();
            check_output($sformatf("hold_cycle%0d", i), sampled_dout, 32'hAA000000);
        end
        idle();
        st_read();
        check_output("hold_status", sampled_dout, 32'h81000000);
        sc_read();
        check_output("hold_next", sampled_dout, 32'hBB000000);
        idle();
        st_read();
        check_output("hold_empty", sampled_dout, 32'h0);

        // Full FIFO: push coincident with pop trigger is accepted without overflow.
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        st_read();
        check_output("full_status", sampled_dout, 32'h88000000);
        sc_read();
        check_output("full_head", sampled_dout, 32'h10000000);
        apply_stimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        st_read();
        check_output("full_push_pop", sampled_dout, 32'h88000000);
        st_write(32'h80000000);
        check_output("full_flush_cycle", sampled_dout, 32'h88000000);
        st_read();
        check_output("full_flushed", sampled_dout, 32'h0);

        // Flush beats a coincident push.
        push(8'h11);
        apply_stimulus(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000000);
        check_output("flush_push_cycle", sampled_dout, 32'h81000000);
        st_read();
        check_output("flush_push_after", sampled_dout, 32'h0);

        // Reset in the middle of an access: that access never pops.
        push(8'h33);
        sc_read();
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        idle();
        st_read();
        check_output("rst_access_status", sampled_dout, 32'h81000000);
        sc_read();
        check_output("rst_access_head", sampled_dout, 32'h55000000);
        idle();
        st_read();
        check_output("rst_access_empty", sampled_dout, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            bit        rst;
            bit        rs;
            bit        pe;
            bit        st;
            bit        sc;
            bit [31:0] din;
            int        sel;
            rst = ($urandom_range(0, 99) == 0);
            rs  = ($urandom_range(0, 2) == 0);
            pe  = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 2);
            st  = (sel == 1);
            sc  = (sel == 2);
            din = $urandom() & 32'h7FFFFFFF;
            if ($urandom_range(0, 15) == 0) din[31] = 1'b1;
            apply_stimulus(rst, rs, 8'($urandom()), pe, st, sc, 1'($urandom()),
                           1'($urandom()), din);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
